// File: rtl/bias_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bias_pkg : layer encodings, bias BRAM address map, fetch FSM state type. r1.0
// ---------------------------------------------------------------------------
package bias_pkg;

  localparam logic [1:0] LAYER_C1  = 2'd0;
  localparam logic [1:0] LAYER_C3  = 2'd1;
  localparam logic [1:0] LAYER_C5  = 2'd2;
  localparam logic [1:0] LAYER_BAD = 2'd3;

  localparam int ADDR_C1_START = 0;
  localparam int ADDR_C1_END   = 1;
  localparam int ADDR_C3_START = 2;
  localparam int ADDR_C3_END   = 5;
  localparam int ADDR_C5_START = 6;
  localparam int ADDR_C5_END   = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int layer_first(input logic [1:0] l);
    case (l)
      LAYER_C3: return ADDR_C3_START;
      LAYER_C5: return ADDR_C5_START;
      default:  return ADDR_C1_START;
    endcase
  endfunction

  function automatic int layer_last(input logic [1:0] l);
    case (l)
      LAYER_C3: return ADDR_C3_END;
      LAYER_C5: return ADDR_C5_END;
      default:  return ADDR_C1_END;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bias_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bias_skid_fifo : 2-entry FIFO absorbing the BRAM read latency. r1.0
// ---------------------------------------------------------------------------
module bias_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Push into a full FIFO is only legal together with a pop: the slot written
  // is the head being retired on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule
`default_nettype wire

// File: rtl/bias_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bias_fetch_ctrl : streams one layer's biases from bias_bram as valid/ready. r1.0
// ---------------------------------------------------------------------------
module bias_fetch_ctrl
  import bias_pkg::*;
#(
  parameter int MEM_SIZE = 49,
  parameter int AWIDTH   = 6,
  parameter int B_BW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        layer,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic [B_BW-1:0]   bias_data,
  output logic              bias_last,
  output logic [AWIDTH-1:0] b_addr0,
  output logic              b_ce0,
  output logic              b_we0,
  output logic [B_BW-1:0]   b_d0,
  input  logic [B_BW-1:0]   b_q0
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [AWIDTH-1:0] end_addr_q, end_addr_d;
  logic              inflight_q, inflight_last_q;
  logic              done_q, err_q;

  logic              accept, reject, pop, issue, issue_last, last_pop;
  logic              fifo_full, fifo_empty;
  logic [B_BW:0]     head;
  logic [2:0]        pending;
  int                last_addr;

  assign accept   = (state_q == ST_IDLE) && start && (layer != LAYER_BAD);
  assign reject   = (state_q == ST_IDLE) && start && (layer == LAYER_BAD);
  assign pop      = bias_valid & bias_ready;
  assign last_pop = (state_q == ST_FLUSH) && pop && bias_last;

  // Words buffered plus the one possibly returning from BRAM must stay below two
  // after this cycle's pop, so a read is never issued without a free slot.
  assign pending  = 3'({fifo_full, ~fifo_empty & ~fifo_full}) + 3'(inflight_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (issue_last) state_d = ST_FLUSH;
      ST_FLUSH: if (last_pop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue      = (state_q == ST_RUN) && (pending < (3'd2 + 3'(pop)));
    issue_last = issue && (rd_addr_q == end_addr_q);
  end

  always_comb begin
    rd_addr_d  = rd_addr_q;
    end_addr_d = end_addr_q;
    last_addr  = layer_last(layer);
    if (last_addr > MEM_SIZE - 1) last_addr = MEM_SIZE - 1;
    if (accept) begin
      rd_addr_d  = AWIDTH'(layer_first(layer));
      end_addr_d = AWIDTH'(last_addr);
    end else if (issue && !issue_last) begin
      rd_addr_d  = rd_addr_q + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q       <= '0;
      end_addr_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      rd_addr_q       <= rd_addr_d;
      end_addr_q      <= end_addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      done_q          <= last_pop;
      err_q           <= reject;
    end
  end

  bias_skid_fifo #(
    .W (B_BW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({inflight_last_q, b_q0}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign bias_valid = ~fifo_empty;
  assign bias_data  = head[B_BW-1:0];
  assign bias_last  = head[B_BW] & ~fifo_empty;
  assign b_ce0      = issue;
  assign b_addr0    = rd_addr_q;
  assign b_we0      = 1'b0;
  assign b_d0       = '0;

endmodule
`default_nettype wire

// File: tb/tb_bias_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bias_fetch_ctrl : scoreboard bench for bias_fetch_ctrl with a BRAM model. r1.0
// ---------------------------------------------------------------------------
module tb_bias_fetch_ctrl;

  localparam int MEM_SIZE = 49;
  localparam int AW       = 6;
  localparam int BW       = 8;

  logic          clk = 1'b0;
  logic          rst, start, bias_ready;
  logic [1:0]    layer;
  logic          busy, done, err, bias_valid, bias_last, b_ce0, b_we0;
  logic [BW-1:0] bias_data, b_d0, b_q0;
  logic [AW-1:0] b_addr0;

  logic [BW-1:0] ram [MEM_SIZE];
  logic [BW:0]   sb_q [$];
  int            vectors     = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (b_ce0) b_q0 <= (b_addr0 < MEM_SIZE) ? ram[b_addr0] : '0;

  bias_fetch_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .AWIDTH   (AW),
    .B_BW     (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .layer      (layer),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready),
    .bias_data  (bias_data),
    .bias_last  (bias_last),
    .b_addr0    (b_addr0),
    .b_ce0      (b_ce0),
    .b_we0      (b_we0),
    .b_d0       (b_d0),
    .b_q0       (b_q0)
  );

  task automatic push_layer(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) sb_q.push_back({1'(a == hi), ram[a]});
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; layer = 2'd0; bias_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, err, bias_valid, bias_last, b_ce0, b_we0} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, expected 0000000", {busy, done, err, bias_valid, bias_last, b_ce0, b_we0});
    end
    vectors++;
    if ({bias_data, b_addr0, b_d0} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: data=%h addr=%0d d0=%h, expected all 0", bias_data, b_addr0, b_d0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_c1();
    logic [BW:0] exp;
    int cyc = 0, first_valid = -1, n_ce = 0;
    bit got_last = 0;
    bias_ready = 1'b1;
    @(negedge clk); start = 1'b1; layer = 2'd0; push_layer(0, 1);
    @(negedge clk); start = 1'b0;
    vectors++;
    if (b_ce0 !== 1'b1 || b_addr0 !== 6'd0) begin
      miscompares++; $display("FAIL c1_first_read: ce=%b addr=%0d, expected 1/0", b_ce0, b_addr0);
    end
    while (!got_last && cyc < 20) begin
      if (b_ce0) begin
        vectors++;
        if (b_addr0 !== AW'(n_ce)) begin
          miscompares++; $display("FAIL c1_addr: got %0d, expected %0d", b_addr0, n_ce);
        end
        n_ce++;
      end
      if (bias_valid && first_valid < 0) first_valid = cyc;
      if (bias_valid && bias_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++; $display("FAIL c1_extra_beat: got %h, expected none", bias_data); got_last = 1;
        end else begin
          exp = sb_q.pop_front();
          if ({bias_last, bias_data} !== exp) begin
            miscompares++; $display("FAIL c1_beat: got %h, expected %h", {bias_last, bias_data}, exp);
          end
          got_last = exp[BW];
        end
      end
      @(negedge clk); cyc++;
    end
    vectors++;
    if (!got_last) begin miscompares++; $display("FAIL c1_timeout: last beat not seen, expected within 20 cycles"); end
    vectors++;
    if (first_valid != 2) begin miscompares++; $display("FAIL c1_latency: valid at %0d, expected 2", first_valid); end
    vectors++;
    if (n_ce != 2) begin miscompares++; $display("FAIL c1_reads: got %0d, expected 2", n_ce); end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL c1_done: done=%b busy=%b, expected 1/0", done, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL c1_done_pulse: got %b, expected 0", done); end
  endtask

  task automatic test_c5_backpressure();
    logic [BW:0] exp, prev_word;
    int cyc = 0, beats = 0, stall = 0, exp_addr = 6;
    bit got_last = 0, prev_stall = 0;
    bias_ready = 1'b0;
    @(negedge clk); start = 1'b1; layer = 2'd2; push_layer(6, 48);
    @(negedge clk); start = 1'b0;
    while (!got_last && cyc < 400) begin
      bias_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        vectors++;
        if (bias_valid !== 1'b1 || {bias_last, bias_data} !== prev_word) begin
          miscompares++; $display("FAIL c5_hold: got v=%b %h, expected 1 %h", bias_valid, {bias_last, bias_data}, prev_word);
        end
      end
      stall = (bias_valid && !bias_ready) ? stall + 1 : 0;
      if (b_ce0) begin
        vectors++;
        if (b_addr0 !== AW'(exp_addr) || b_addr0 > 6'd48) begin
          miscompares++; $display("FAIL c5_addr: got %0d, expected %0d", b_addr0, exp_addr);
        end
        exp_addr++;
      end
      if (stall >= 3) begin
        vectors++;
        if (b_ce0 !== 1'b0) begin miscompares++; $display("FAIL c5_stall_read: ce=%b, expected 0", b_ce0); end
      end
      if (bias_valid && bias_ready) begin
        vectors++; beats++;
        if (sb_q.size() == 0) begin
          miscompares++; $display("FAIL c5_extra_beat: got %h, expected none", bias_data); got_last = 1;
        end else begin
          exp = sb_q.pop_front();
          if ({bias_last, bias_data} !== exp) begin
            miscompares++; $display("FAIL c5_beat: beat %0d got %h, expected %h", beats, {bias_last, bias_data}, exp);
          end
          got_last = exp[BW];
        end
      end
      prev_stall = bias_valid && !bias_ready;
      prev_word  = {bias_last, bias_data};
      @(negedge clk); cyc++;
    end
    bias_ready = 1'b1;
    vectors++;
    if (beats != 43 || !got_last) begin
      miscompares++; $display("FAIL c5_count: got %0d beats, expected 43", beats);
    end
    vectors++;
    if (exp_addr != 49) begin miscompares++; $display("FAIL c5_reads: next addr %0d, expected 49", exp_addr); end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL c5_done: done=%b busy=%b, expected 1/0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk); start = 1'b1; layer = 2'd3;
    @(negedge clk); start = 1'b0;
    vectors++;
    if ({err, busy, b_ce0} !== 3'b100) begin
      miscompares++; $display("FAIL illegal_err: err/busy/ce=%b, expected 100", {err, busy, b_ce0});
    end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({err, busy, b_ce0, bias_valid} !== 4'b0) begin
        miscompares++; $display("FAIL illegal_idle: err/busy/ce/valid=%b, expected 0000", {err, busy, b_ce0, bias_valid});
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [BW:0] exp;
    int cyc = 0, beats = 0, exp_addr = 2;
    bit got_last = 0;
    bias_ready = 1'b1;
    @(negedge clk); start = 1'b1; layer = 2'd1; push_layer(2, 5);
    @(negedge clk); start = 1'b0;
    while (!got_last && cyc < 30) begin
      start = (cyc == 1);
      layer = (cyc == 1) ? 2'd0 : 2'd1;
      if (b_ce0) begin
        vectors++;
        if (b_addr0 !== AW'(exp_addr)) begin
          miscompares++; $display("FAIL c3_addr: got %0d, expected %0d", b_addr0, exp_addr);
        end
        exp_addr++;
      end
      if (bias_valid && bias_ready) begin
        vectors++; beats++;
        if (sb_q.size() == 0) begin
          miscompares++; $display("FAIL c3_extra_beat: got %h, expected none", bias_data); got_last = 1;
        end else begin
          exp = sb_q.pop_front();
          if ({bias_last, bias_data} !== exp) begin
            miscompares++; $display("FAIL c3_beat: got %h, expected %h", {bias_last, bias_data}, exp);
          end
          got_last = exp[BW];
        end
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    vectors++;
    if (beats != 4 || !got_last) begin miscompares++; $display("FAIL c3_count: got %0d beats, expected 4", beats); end
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL c3_done: got %b, expected 1", done); end
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({busy, b_ce0, bias_valid} !== 3'b0) begin
        miscompares++; $display("FAIL c3_restart: busy/ce/valid=%b, expected 000", {busy, b_ce0, bias_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [BW:0] exp;
    int cyc = 0, beats = 0;
    bit got_last = 0;
    bias_ready = 1'b1;
    @(negedge clk); start = 1'b1; layer = 2'd2; push_layer(6, 48);
    @(negedge clk); start = 1'b0;
    while (beats < 10 && cyc < 40) begin
      if (bias_valid && bias_ready) beats++;
      @(negedge clk); cyc++;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err, bias_valid, bias_last, b_ce0} !== 6'b0 || {bias_data, b_addr0} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: ctrl=%b data=%h addr=%0d, expected all 0",
               {busy, done, err, bias_valid, bias_last, b_ce0}, bias_data, b_addr0);
    end
    sb_q.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, bias_valid} !== 3'b0) begin
      miscompares++; $display("FAIL mid_reset_idle: busy/done/valid=%b, expected 000", {busy, done, bias_valid});
    end
    start = 1'b1; layer = 2'd0; push_layer(0, 1);
    @(negedge clk); start = 1'b0;
    beats = 0; cyc = 0;
    while (!got_last && cyc < 20) begin
      if (bias_valid && bias_ready) begin
        vectors++; beats++;
        if (sb_q.size() == 0) begin
          miscompares++; $display("FAIL post_reset_extra: got %h, expected none", bias_data); got_last = 1;
        end else begin
          exp = sb_q.pop_front();
          if ({bias_last, bias_data} !== exp) begin
            miscompares++; $display("FAIL post_reset_beat: got %h, expected %h", {bias_last, bias_data}, exp);
          end
          got_last = exp[BW];
        end
      end
      @(negedge clk); cyc++;
    end
    vectors++;
    if (beats != 2 || done !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_fetch: beats=%0d done=%b, expected 2/1", beats, done);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) ram[i] = BW'($urandom);
    test_reset();
    test_c1();
    test_c5_backpressure();
    test_illegal();
    test_restart_ignored();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bias_fetch_ctrl.md
# bias_fetch_ctrl

Sequencer that streams per-layer bias values out of `bias_bram` to the convolution/FC compute engine. On a `start` with a layer index it walks that layer's address range on BRAM port 0. It absorbs the BRAM's 1-cycle registered read latency in a 2-entry buffer and presents the biases as a valid/ready stream with a last marker. It sits between the layer scheduler, which issues `start`, and the PE array's bias adder.

## Interface
Parameters:
- `MEM_SIZE`, 49, bias BRAM depth (must match `bias_bram`)
- `AWIDTH`, 6, BRAM address width
- `B_BW`, 8, bias word width

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  begin fetch of `layer`; sampled only in IDLE
- `layer`  in  2  0=C1, 1=C3, 2=C5, 3=illegal
- `busy`  out  1  high from the edge after an accepted `start` until `done`
- `done`  out  1  1-cycle pulse after the last beat handshakes
- `err`  out  1  1-cycle pulse when `start` arrives with `layer`=3
- `bias_valid`  out  1  stream valid
- `bias_ready`  in  1  consumer ready
- `bias_data`  out  B_BW  bias word
- `bias_last`  out  1  high with the final beat of the layer
- `b_addr0`  out  AWIDTH  BRAM port-0 address
- `b_ce0`  out  1  BRAM port-0 enable
- `b_we0`  out  1  tied 0; this block only reads
- `b_d0`  out  B_BW  tied 0
- `b_q0`  in  B_BW  BRAM port-0 read data, valid the cycle after `b_ce0`

## Operation
- Layer ranges (inclusive): C1 0..1, C3 2..5, C5 6..48.
- FSM states: IDLE, RUN, FLUSH.
- IDLE → RUN: `start` & `layer`≠3. Latch `rd_addr`=start address and `end_addr`; `busy`←1.
- IDLE with `start` & `layer`=3: pulse `err`, stay IDLE, issue no reads.
- `start` outside IDLE is ignored.
- RUN: assert `b_ce0` with `b_addr0`=`rd_addr` whenever (occupancy + in_flight − pop) < 2, where pop = `bias_valid` & `bias_ready`.
  - Each issue increments `rd_addr`.
  - The issue at `rd_addr`=`end_addr` tags that read as last and moves to FLUSH.
- In-flight tracking: a 1-bit `in_flight` register carries the issue flag and the last tag. The next cycle, `b_q0` plus the tag are pushed into the buffer.
- FLUSH: no new reads. When the last-tagged entry pops: `done` pulse, `busy`←0, state→IDLE.
- `bias_valid` = buffer non-empty. `bias_data` and `bias_last` come from the buffer head and hold stable while `bias_valid` & !`bias_ready`.
- Beat counts: C1 2 beats, C3 4 beats, C5 43 beats.
- Addresses never exceed `end_addr`. No wrap; `rd_addr` never reaches `MEM_SIZE`.

## Timing
- Reset (async, any state): state=IDLE. `busy`, `done`, `err`, `bias_valid`, `bias_last`, `b_ce0` = 0. `bias_data` and `b_addr0` = 0. Buffer emptied and in-flight read discarded. A fetch interrupted mid-layer is abandoned with no `done`.
- Latency with `start` sampled at edge N:
  - `b_ce0` is high during cycle N+1.
  - `bias_valid` rises after edge N+2.
- Throughput: 1 beat/cycle while `bias_ready` is held high.
- `done` is asserted the cycle after the edge on which the last beat handshakes. `busy` falls on that same edge.
- A new `start` is accepted at the earliest one cycle after `done`.
- Backpressure: with `bias_ready` low, at most 2 words are buffered and `b_ce0` stays low; no data is lost or duplicated.
- Simultaneous push and pop with a full buffer is legal; occupancy is unchanged.

## Structure
- Shared package `bias_pkg` holds:
  - layer encodings LAYER_C1/C3/C5
  - ADDR_*_START/ADDR_*_END constants
  - the FSM state typedef
- `bias_bram` uses the same package constants.
- One sub-module: `bias_skid_fifo`, a 2-entry FIFO with width B_BW+1 (data + last), push/pop, full/empty.

## Test plan
- Reset then `start` with `layer`=0 and `bias_ready`=1. Expect `b_addr0` 0,1; beats ram[0], ram[1] with `bias_last` on the 2nd beat; `done` one cycle later; first `bias_valid` 2 cycles after `start`.
- `layer`=2 with `bias_ready` toggling 1,0,0,1 pseudo-randomly. Expect exactly 43 beats equal to ram[6..48] in order, `bias_last` only on ram[48], and `b_addr0` never above 48.
- `start` with `layer`=3. Expect an `err` pulse, no `b_ce0`, and `busy` staying 0.
- `start` with `layer`=1 pulsed again mid-fetch. Expect the second start ignored and exactly 4 beats from ram[2..5].
- Assert `rst` after the 10th C5 beat. Expect all outputs at 0 immediately. A following `layer`=0 fetch completes normally with 2 beats.
